// File: rtl/type_rule_cfg_ctrl.sv
// Config sequencer for the type-lookup rule table: assembles word-serial rule
// commands and commits them one rule per cycle once the lookup path is idle.
//
// state   | meaning
// IDLE    | ready for the first beat of a command
// COLLECT | gathering the remaining WRITE beats
// DRAIN   | malformed command, swallowing beats up to last
// WAIT_Q  | command complete, holding off until the datapath is quiescent
// COMMIT  | single-rule write (WRITE / INVALIDATE)
// CLEAR   | invalidating every rule, one per cycle
module type_rule_cfg_ctrl #(
    parameter int RULE_NUM  = 8,
    parameter int RULE_BITS = 200,
    parameter int CFG_WIDTH = 32,
    localparam int BEATS    = (RULE_BITS + CFG_WIDTH - 1) / CFG_WIDTH,
    localparam int IDX_W    = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [CFG_WIDTH-1:0] i_cfg_data,
    input  logic                 i_cfg_last,
    input  logic [1:0]           i_cfg_cmd,
    input  logic [IDX_W-1:0]     i_cfg_idx,
    input  logic                 i_quiesce_ok,
    input  logic                 i_err_clr,
    output logic [RULE_NUM-1:0]  o_rule_wren,
    output logic                 o_rule_valid,
    output logic [RULE_BITS-1:0] o_rule_payload,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err
);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [1:0] CMD_WRITE = 2'd0;
    localparam logic [1:0] CMD_INVAL = 2'd1;
    localparam logic [1:0] CMD_CLEAR = 2'd2;
    localparam logic [1:0] CMD_RSVD  = 2'd3;

    typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, WAIT_Q, COMMIT, CLEAR} state_t;

    state_t                state_q, state_d;
    logic [1:0]            cmd_q, cmd_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [RULE_BITS-1:0]  asm_q, asm_d;
    logic [IDX_W-1:0]      clr_q, clr_d;
    logic [RULE_NUM-1:0]   wren_q, wren_d;
    logic                  valid_q, valid_d;
    logic [RULE_BITS-1:0]  pay_q, pay_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  set_err;
    logic                  idx_bad;
    logic [BEAT_W-1:0]     beat_idx;

    assign o_cfg_ready    = (state_q == IDLE) || (state_q == COLLECT) || (state_q == DRAIN);
    assign o_busy         = (state_q != IDLE);
    assign o_rule_wren    = wren_q;
    assign o_rule_valid   = valid_q;
    assign o_rule_payload = pay_q;
    assign o_done         = done_q;
    assign o_err          = err_q;

    assign idx_bad  = ({1'b0, i_cfg_idx} >= (IDX_W + 1)'(RULE_NUM));
    assign beat_idx = (state_q == IDLE) ? '0 : beat_q;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        clr_d   = clr_q;
        wren_d  = '0;
        valid_d = 1'b0;
        pay_d   = '0;
        done_d  = 1'b0;
        set_err = 1'b0;

        // Beats beyond RULE_BITS fall off the end of the assembly register.
        if (i_cfg_valid && (state_q == IDLE || state_q == COLLECT)) begin
            for (int b = 0; b < CFG_WIDTH; b++) begin
                if (int'(beat_idx) * CFG_WIDTH + b < RULE_BITS)
                    asm_d[int'(beat_idx) * CFG_WIDTH + b] = i_cfg_data[b];
            end
        end

        case (state_q)
            IDLE: begin
                if (i_cfg_valid) begin
                    cmd_d  = i_cfg_cmd;
                    idx_d  = i_cfg_idx;
                    beat_d = BEAT_W'(1);
                    if (i_cfg_cmd == CMD_RSVD || idx_bad) begin
                        if (i_cfg_last) set_err = 1'b1;
                        else            state_d = DRAIN;
                    end else if (i_cfg_cmd == CMD_WRITE && BEATS > 1) begin
                        if (i_cfg_last) set_err = 1'b1;
                        else            state_d = COLLECT;
                    end else begin
                        state_d = i_cfg_last ? WAIT_Q : DRAIN;
                    end
                end
            end
            COLLECT: begin
                if (i_cfg_valid) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = i_cfg_last ? WAIT_Q : DRAIN;
                    end else if (i_cfg_last) begin
                        state_d = IDLE;
                        set_err = 1'b1;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (i_cfg_valid && i_cfg_last) begin
                    state_d = IDLE;
                    set_err = 1'b1;
                end
            end
            WAIT_Q: begin
                if (i_quiesce_ok) begin
                    if (cmd_q == CMD_CLEAR) begin
                        state_d = CLEAR;
                        clr_d   = '0;
                        wren_d  = RULE_NUM'(1);
                        done_d  = (RULE_NUM == 1);
                    end else begin
                        state_d = COMMIT;
                        wren_d  = RULE_NUM'(1) << idx_q;
                        valid_d = (cmd_q == CMD_WRITE);
                        pay_d   = (cmd_q == CMD_WRITE) ? asm_q : '0;
                        done_d  = 1'b1;
                    end
                end
            end
            COMMIT: state_d = IDLE;
            CLEAR: begin
                if (clr_q == IDX_W'(RULE_NUM - 1)) begin
                    state_d = IDLE;
                end else begin
                    clr_d  = clr_q + 1'b1;
                    wren_d = RULE_NUM'(1) << (clr_q + 1'b1);
                    done_d = (clr_q == IDX_W'(RULE_NUM - 2));
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = err_q;
        if (i_err_clr) err_d = 1'b0;
        if (set_err)   err_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cmd_q   <= CMD_WRITE;
            idx_q   <= '0;
            beat_q  <= '0;
            asm_q   <= '0;
            clr_q   <= '0;
            wren_q  <= '0;
            valid_q <= 1'b0;
            pay_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            clr_q   <= clr_d;
            wren_q  <= wren_d;
            valid_q <= valid_d;
            pay_q   <= pay_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    logic unused_inval;
    assign unused_inval = (CMD_INVAL == 2'd1);

endmodule

// File: tb/tb_type_rule_cfg_ctrl.sv
// Randomized bench for type_rule_cfg_ctrl: a command-level model predicts every
// table write (cycle, enable, valid, payload, done) plus ready/busy/err windows.
module tb_type_rule_cfg_ctrl;
    localparam int RULE_NUM  = 8;
    localparam int RULE_BITS = 200;
    localparam int CFG_WIDTH = 32;
    localparam int BEATS     = (RULE_BITS + CFG_WIDTH - 1) / CFG_WIDTH;
    localparam int IDX_W     = $clog2(RULE_NUM);
    localparam logic [1:0] C_WR = 2'd0, C_INV = 2'd1, C_CLR = 2'd2, C_RSV = 2'd3;
    localparam logic [7:0] SWEEP [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_cfg_valid;
    logic                 o_cfg_ready;
    logic [CFG_WIDTH-1:0] i_cfg_data;
    logic                 i_cfg_last;
    logic [1:0]           i_cfg_cmd;
    logic [IDX_W-1:0]     i_cfg_idx;
    logic                 i_quiesce_ok;
    logic                 i_err_clr;
    logic [RULE_NUM-1:0]  o_rule_wren;
    logic                 o_rule_valid;
    logic [RULE_BITS-1:0] o_rule_payload;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;

    type_rule_cfg_ctrl #(.RULE_NUM(RULE_NUM), .RULE_BITS(RULE_BITS), .CFG_WIDTH(CFG_WIDTH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
        .i_cfg_data(i_cfg_data), .i_cfg_last(i_cfg_last), .i_cfg_cmd(i_cfg_cmd), .i_cfg_idx(i_cfg_idx),
        .i_quiesce_ok(i_quiesce_ok), .i_err_clr(i_err_clr), .o_rule_wren(o_rule_wren),
        .o_rule_valid(o_rule_valid), .o_rule_payload(o_rule_payload), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int                   cyc;
        logic [RULE_NUM-1:0]  wren;
        logic                 valid;
        logic [RULE_BITS-1:0] payload;
        logic                 done;
    } wr_t;

    wr_t  exp_q[$];
    wr_t  obs_q[$];
    wr_t  ce;
    wr_t  ob;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   win_lo = -1, win_hi = -2;
    int   busy_lo = -1, busy_hi = -2;
    logic exp_err = 1'b0;
    logic [CFG_WIDTH-1:0] bdat [16];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [RULE_BITS-1:0] act, input logic [RULE_BITS-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    // Per-cycle compare against the model's expected write schedule and windows.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            chk("rst_wren", o_rule_wren, '0);
            chk("rst_valid", o_rule_valid, '0);
            chk("rst_payload", o_rule_payload, '0);
            chk("rst_done", o_done, '0);
            chk("rst_err", o_err, '0);
            chk("rst_busy", o_busy, '0);
            chk("rst_ready", o_cfg_ready, 1);
        end else begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_write expected_at=%0d now=%0d", exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                ce = exp_q.pop_front();
                chk("wren", o_rule_wren, ce.wren);
                chk("valid", o_rule_valid, ce.valid);
                chk("payload", o_rule_payload, ce.payload);
                chk("done", o_done, ce.done);
            end else begin
                chk("idle_wren", o_rule_wren, '0);
                chk("idle_valid", o_rule_valid, '0);
                chk("idle_payload", o_rule_payload, '0);
                chk("idle_done", o_done, '0);
            end
            if (o_rule_wren != '0) begin
                ob.cyc = cyc; ob.wren = o_rule_wren; ob.valid = o_rule_valid;
                ob.payload = o_rule_payload; ob.done = o_done;
                obs_q.push_back(ob);
            end
            chk("err", o_err, exp_err);
            chk("ready", o_cfg_ready, !(cyc >= win_lo && cyc <= win_hi));
            chk("busy", o_busy, (cyc >= busy_lo && cyc <= busy_hi));
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Drives one command (last on the final beat) and schedules the expected writes.
    task automatic send(input logic [1:0] cmd, input int idx, input int nb, input int qwait,
                        input bit hold, output int t_last);
        int   first_c, req, n, w0, budget;
        logic ok;
        logic [BEATS*CFG_WIDTH-1:0] big;
        wr_t  e;
        big = '0;
        first_c = 0;
        t_last = 0;
        for (int b = 0; b < nb; b++) begin
            i_cfg_valid  = 1'b1;
            i_cfg_data   = bdat[b];
            i_cfg_last   = (b == nb - 1);
            i_cfg_cmd    = (b == 0) ? cmd : 2'($urandom);
            i_cfg_idx    = (b == 0) ? IDX_W'(idx) : IDX_W'($urandom);
            i_quiesce_ok = 1'($urandom);
            if (b < BEATS) big[b*CFG_WIDTH +: CFG_WIDTH] = bdat[b];
            budget = 0;
            @(negedge i_clk);
            while (!o_cfg_ready) begin
                budget++;
                if (budget > 50) begin
                    $display("FAIL ready_timeout cyc=%0d actual=0 required=1", cyc);
                    $fatal(1, "ready never returned");
                end
                @(negedge i_clk);
            end
            if (b == 0) first_c = cyc;
            t_last = cyc;
            step();
            if (b == 0) begin
                busy_lo = first_c + 1;
                busy_hi = 1 << 30;
            end
        end
        i_cfg_valid = 1'b0;
        i_cfg_last  = 1'b0;
        req = (cmd == C_WR) ? BEATS : 1;
        ok  = (cmd != C_RSV) && (idx < RULE_NUM) && (nb == req);
        if (!ok) begin
            exp_err = 1'b1;
            busy_hi = t_last;
            i_quiesce_ok = 1'($urandom);
        end else begin
            w0 = t_last + 2 + qwait;
            n  = (cmd == C_CLR) ? RULE_NUM : 1;
            for (int i = 0; i < n; i++) begin
                e.cyc     = w0 + i;
                e.wren    = RULE_NUM'(1) << ((cmd == C_CLR) ? i : idx);
                e.valid   = (cmd == C_WR);
                e.payload = (cmd == C_WR) ? big[RULE_BITS-1:0] : '0;
                e.done    = (i == n - 1);
                exp_q.push_back(e);
            end
            win_lo  = t_last + 1;
            win_hi  = w0 + n - 1;
            busy_hi = win_hi;
            i_quiesce_ok = 1'b0;
            if (!hold) begin
                for (int q = 0; q < qwait; q++) step();
                i_quiesce_ok = 1'b1;
                while (cyc <= win_hi) step();
            end
        end
    endtask

    task automatic clr_err();
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        exp_err = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t, k, nb, idx, qw;
        wr_t o;
        logic [1:0] cmd;
        i_rst_n = 1'b0; i_cfg_valid = 1'b0; i_cfg_data = '0; i_cfg_last = 1'b0;
        i_cfg_cmd = '0; i_cfg_idx = '0; i_quiesce_ok = 1'b0; i_err_clr = 1'b0;
        repeat (3) step();
        i_rst_n = 1'b1;
        step();

        for (int b = 0; b < BEATS; b++) bdat[b] = 32'(32'h11111111 * (b + 1));
        obs_q.delete();
        send(C_WR, 3, BEATS, 0, 1'b0, t);
        chk("t1_count", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            o = obs_q[0];
            chk("t1_wren", o.wren, 8'h08);
            chk("t1_valid", o.valid, 1);
            chk("t1_pay_lo", o.payload[31:0], 32'h11111111);
            chk("t1_pay_hi", o.payload[199:192], 8'h77);
            chk("t1_done", o.done, 1);
            chk("t1_latency", o.cyc - t, 2);
        end

        obs_q.delete();
        send(C_WR, 3, BEATS, 5, 1'b0, t);
        chk("t2_count", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            o = obs_q[0];
            chk("t2_latency", o.cyc - t, 7);
            chk("t2_wren", o.wren, 8'h08);
        end

        obs_q.delete();
        send(C_CLR, 0, 1, 0, 1'b0, t);
        chk("t3_count", obs_q.size(), 8);
        if (obs_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                o = obs_q[i];
                chk("t3_wren", o.wren, SWEEP[i]);
                chk("t3_valid", o.valid, 0);
                chk("t3_payload", o.payload, '0);
                chk("t3_done", o.done, (i == 7));
                chk("t3_cycle", o.cyc - t, 2 + i);
            end
        end

        obs_q.delete();
        for (int b = 0; b < 16; b++) bdat[b] = $urandom;
        send(C_WR, 1, 3, 0, 1'b0, t);
        step(); step();
        chk("t4_count", obs_q.size(), 0);
        @(negedge i_clk);
        chk("t4_err_set", o_err, 1);
        step();
        clr_err();
        @(negedge i_clk);
        chk("t4_err_clr", o_err, 0);
        step();

        obs_q.delete();
        send(C_WR, 2, 10, 0, 1'b0, t);
        step(); step();
        chk("t5_count", obs_q.size(), 0);
        @(negedge i_clk);
        chk("t5_err_set", o_err, 1);
        step();
        send(C_INV, 5, 1, 0, 1'b0, t);
        chk("t5_inv_count", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            o = obs_q[0];
            chk("t5_inv_wren", o.wren, 8'h20);
            chk("t5_inv_valid", o.valid, 0);
        end
        clr_err();

        obs_q.delete();
        send(C_WR, 6, BEATS, 20, 1'b1, t);
        repeat (3) step();
        i_rst_n = 1'b0;
        exp_q.delete();
        win_lo = -1; win_hi = -2; busy_lo = -1; busy_hi = -2;
        exp_err = 1'b0;
        repeat (2) step();
        i_rst_n = 1'b1;
        i_quiesce_ok = 1'b1;
        repeat (12) step();
        chk("t6_no_write", obs_q.size(), 0);

        for (int r = 0; r < 60; r++) begin
            for (int b = 0; b < 16; b++) bdat[b] = $urandom;
            k   = $urandom_range(0, 9);
            idx = $urandom_range(0, RULE_NUM - 1);
            qw  = $urandom_range(0, 4);
            case (k)
                0, 1, 2: begin cmd = C_WR;  nb = BEATS; end
                3, 4:    begin cmd = C_INV; nb = 1; end
                5:       begin cmd = C_CLR; nb = 1; end
                6:       begin cmd = C_RSV; nb = $urandom_range(1, 3); end
                7:       begin cmd = C_WR;  nb = $urandom_range(1, BEATS - 1); end
                8:       begin cmd = C_WR;  nb = $urandom_range(BEATS + 1, BEATS + 4); end
                default: begin cmd = 2'($urandom_range(1, 2)); nb = $urandom_range(2, 3); end
            endcase
            send(cmd, idx, nb, qw, 1'b0, t);
            repeat ($urandom_range(0, 2)) begin
                i_quiesce_ok = 1'($urandom);
                step();
            end
            if (exp_err && $urandom_range(0, 2) == 0) clr_err();
        end
        repeat (12) step();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
